track_sensor_conditioner: RTL
=============================

Name: track_sensor_conditioner

Overview:
Input front end for the train controller top level. Takes the six raw track-sensor lines S1..S6 from board pins and synchronises and debounces each one. Produces clean per-sensor levels and single-cycle edge pulses. Edges are serialised into an arrival/departure event stream with a valid/ready handshake, which the controller FSM consumes one event at a time.

Parameters:
NUM_SENSORS, 6, number of sensor channels (bit 0 = S1 ... bit 5 = S6)
SYNC_STAGES, 2, synchroniser flops per channel (minimum 2)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (10 ms at 100 MHz)
CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived)

Ports:
clk_100mhz  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
s_raw  input  NUM_SENSORS  raw asynchronous sensor inputs, 1 = train present
s_level  output  NUM_SENSORS  debounced sensor level
s_rise  output  NUM_SENSORS  one-cycle pulse when s_level bit goes 0->1
s_fall  output  NUM_SENSORS  one-cycle pulse when s_level bit goes 1->0
evt_valid  output  1  event slot holds an event
evt_id  output  3  sensor index of event (0..NUM_SENSORS-1)
evt_dir  output  1  1 = arrival (rise), 0 = departure (fall)
evt_ready  input  1  consumer accepts event this cycle
evt_overflow  output  1  sticky: an edge was lost
ovf_clr  input  1  clears evt_overflow

Behaviour:
- Reset (async assert, sync release): sync flops, debounce counters, s_level, s_rise, s_fall, pending bits, evt_valid, evt_id, evt_dir and evt_overflow all 0.
- Synchroniser: SYNC_STAGES flop chain per channel. Only the last stage is used.
- Debounce, per channel:
  - If sync != s_level, the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and sync still differs, s_level <= sync and the counter clears.
  - If sync == s_level, the counter clears. Any glitch shorter than DEBOUNCE_CYCLES therefore produces no change.
- Latency raw->s_level: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- s_rise/s_fall are registered. They are high exactly in the first cycle the new s_level is visible.
- Pending register: 2*NUM_SENSORS bits (rise_pend, fall_pend). An edge pulse in cycle t sets its bit at the edge ending cycle t.
- Output slot load: when !evt_valid, or evt_valid && evt_ready, the slot loads the highest-priority pending bit and clears it in the same edge. evt_valid = 1 if any bit was pending, else 0.
- Priority: lowest sensor index first; for the same index, rise before fall.
- Earliest evt_valid is 2 cycles after the s_rise/s_fall pulse.
- With evt_ready held 1, throughput is 1 event/cycle.
- evt_id/evt_dir are stable while evt_valid && !evt_ready.
- Overflow:
  - An edge pulse arriving for a bit already pending sets evt_overflow; the pending bit stays 1.
  - A pulse for the bit being loaded into the slot in that same cycle re-sets the pending bit and does not flag overflow.
- ovf_clr clears evt_overflow. If a set and ovf_clr occur in the same cycle, set wins.
- Sensors held at 1 through reset release produce a rise event after the normal latency, because reset state is "all clear".

Decomposition:
- Package train_pkg holds:
  - NUM_SENSORS
  - EVT_ARRIVE=1'b1 and EVT_DEPART=1'b0
  - the sensor-index width constant
- Sub-module sensor_debounce handles one channel (synchroniser, counter, level, rise/fall pulses). It is instantiated NUM_SENSORS times via generate.
- Pending/arbiter/slot logic lives in the parent.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2):
1. Hold rst_n=0 with s_raw=6'h3F -> all outputs 0; release -> s_level=6'h3F after 10 cycles, six rise events id 0..5 on consecutive cycles with evt_ready=1.
2. s_raw[0] high for 5 cycles then low -> s_level, s_rise and evt_valid never assert.
3. s_raw[0] held high, evt_ready=1 -> s_rise[0] pulse 10 cycles later; evt_valid=1 with id=0, dir=1 for exactly one cycle, 2 cycles after the pulse.
4. s_raw[1] and s_raw[2] rise in the same cycle, evt_ready=0 -> evt_valid holds id=1 stable; raise evt_ready -> id=1, then id=2 next cycle, then evt_valid=0.
5. evt_ready=0, slot holds id=0. Toggle s_raw[3] rise, fall, rise, each held 12 cycles -> evt_overflow=1 on the second rise. Pulse ovf_clr -> 0. Draining yields id3 rise then id3 fall.
6. Assert rst_n=0 midway through a debounce count and with events pending -> all outputs 0 immediately; after release no stale event appears.

Source files
------------

// File: rtl/train_pkg.sv
// train_pkg: shared sensor count, event direction codes and index width.
package train_pkg;
  localparam int NUM_SENSORS = 6;
  localparam int ID_W = 3;
  localparam logic EVT_ARRIVE = 1'b1;
  localparam logic EVT_DEPART = 1'b0;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: one channel of synchroniser, stability counter, level and edge pulses.
module sensor_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic s, diff, flip;
  assign s = sync[SYNC_STAGES-1];
  assign diff = s != level;
  assign flip = diff && cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], raw};
      cnt   <= diff && !flip ? cnt + 1'b1 : '0;
      level <= flip ? s : level;
      rise  <= flip && s;
      fall  <= flip && !s;
    end
endmodule

// File: rtl/track_sensor_conditioner.sv
// track_sensor_conditioner: debounces the track sensors and serialises their edges
// into a prioritised arrival/departure event stream with sticky overflow.
module track_sensor_conditioner
  import train_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                   clk_100mhz,
  input  logic                   rst_n,
  input  logic [NUM_SENSORS-1:0] s_raw,
  output logic [NUM_SENSORS-1:0] s_level,
  output logic [NUM_SENSORS-1:0] s_rise,
  output logic [NUM_SENSORS-1:0] s_fall,
  output logic                   evt_valid,
  output logic [ID_W-1:0]        evt_id,
  output logic                   evt_dir,
  input  logic                   evt_ready,
  output logic                   evt_overflow,
  input  logic                   ovf_clr
);
  localparam int PW = 2 * NUM_SENSORS;
  localparam int SEL_W = $clog2(PW);
  logic [PW-1:0] pend, edges, low, rem;
  logic [SEL_W-1:0] sel;
  logic load;
  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    sensor_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_db (
      .clk(clk_100mhz),
      .rst_n(rst_n),
      .raw(s_raw[i]),
      .level(s_level[i]),
      .rise(s_rise[i]),
      .fall(s_fall[i])
    );
    assign edges[2*i]   = s_rise[i];
    assign edges[2*i+1] = s_fall[i];
  end
  // Even bits are rises, odd bits falls, so the lowest set bit is the winner.
  assign load = !evt_valid || evt_ready;
  assign low  = pend & (~pend + 1'b1);
  assign rem  = load ? pend & ~low : pend;
  always_comb begin
    sel = '0;
    for (int k = 0; k < PW; k++)
      if (low[k]) sel = SEL_W'(k);
  end
  always_ff @(posedge clk_100mhz or negedge rst_n)
    if (!rst_n) begin
      pend         <= '0;
      evt_valid    <= 1'b0;
      evt_id       <= '0;
      evt_dir      <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      pend         <= rem | edges;
      evt_overflow <= |(edges & rem) || (evt_overflow && !ovf_clr);
      if (load) begin
        evt_valid <= |pend;
        if (|pend) begin
          evt_id  <= ID_W'(sel >> 1);
          evt_dir <= sel[0] ? EVT_DEPART : EVT_ARRIVE;
        end
      end
    end
endmodule
